// File: rtl/modex_engine_if.sv
// Operand/result handshake bundle for the modular-exponentiation engine.
// The master side supplies operands and accepts results; the engine is the slave.
`timescale 1ns/1ps
interface modex_engine_if #(
  parameter int WIDTH     = 16,
  parameter int EXP_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     base;
  logic [EXP_WIDTH-1:0] exponent;
  logic [WIDTH-1:0]     modulus;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     result;
  logic                 error;

  modport master (
    output in_valid, base, exponent, modulus, out_ready,
    input  in_ready, out_valid, result, error
  );

  modport slave (
    input  in_valid, base, exponent, modulus, out_ready,
    output in_ready, out_valid, result, error
  );
endinterface

// File: rtl/modex_engine.sv
// Constant-time right-to-left square-and-multiply engine: result = base^exponent mod modulus.
// Two bit-serial interleaved modular multipliers compute acc*sq and sq*sq side by side.
`timescale 1ns/1ps
module modex_engine #(
  parameter int WIDTH     = 16,
  parameter int EXP_WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  modex_engine_if.slave bus
);

  localparam int JW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int KW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH + 1) : 1;
  localparam logic [JW-1:0] J_LAST = JW'(WIDTH - 1);
  localparam logic [KW-1:0] K_LAST = KW'(EXP_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CHECK, MUL, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     base_q;
  logic [WIDTH-1:0]     mod_q;
  logic [EXP_WIDTH-1:0] exp_q;
  logic [WIDTH-1:0]     acc_q;
  logic [WIDTH-1:0]     sq_q;
  logic [WIDTH:0]       r1_q;
  logic [WIDTH:0]       r2_q;
  logic [JW-1:0]        j_q;
  logic [KW-1:0]        k_q;
  logic                 err_q;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     result_q;
  logic                 error_q;

  logic [JW-1:0]        bit_idx;
  logic                 ybit;
  logic [WIDTH:0]       p1;
  logic [WIDTH:0]       p2;
  logic                 chk_mod1;
  logic                 chk_bad;
  logic                 bit_last;
  logic                 exp_last;

  // One interleaved shift-add step; r < n on entry keeps every intermediate below 2n.
  function automatic logic [WIDTH:0] mod_step(
    input logic [WIDTH:0]   r,
    input logic [WIDTH-1:0] x,
    input logic             yb,
    input logic [WIDTH-1:0] n
  );
    logic [WIDTH:0] t;
    logic [WIDTH:0] nn;
    nn = {1'b0, n};
    t  = {r[WIDTH-1:0], 1'b0};
    if (t >= nn) t = t - nn;
    if (yb) begin
      t = t + {1'b0, x};
      if (t >= nn) t = t - nn;
    end
    return t;
  endfunction

  assign bit_idx  = J_LAST - j_q;
  assign ybit     = sq_q[bit_idx];
  assign p1       = mod_step(r1_q, acc_q, ybit, mod_q);
  assign p2       = mod_step(r2_q, sq_q, ybit, mod_q);
  assign chk_mod1 = (mod_q == WIDTH'(1));
  assign chk_bad  = (mod_q < WIDTH'(2)) || (base_q >= mod_q);
  assign bit_last = (j_q == J_LAST);
  assign exp_last = (k_q == K_LAST);

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.error     = error_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.in_valid) state_d = CHECK;
      CHECK: state_d = chk_bad ? DONE : MUL;
      MUL:   if (bit_last && exp_last) state_d = DONE;
      DONE:  if (out_valid_q && bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q      <= '0;
      mod_q       <= '0;
      exp_q       <= '0;
      acc_q       <= '0;
      sq_q        <= '0;
      r1_q        <= '0;
      r2_q        <= '0;
      j_q         <= '0;
      k_q         <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      error_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            base_q <= bus.base;
            exp_q  <= bus.exponent;
            mod_q  <= bus.modulus;
          end
        end
        CHECK: begin
          r1_q <= '0;
          r2_q <= '0;
          j_q  <= '0;
          k_q  <= '0;
          // modulus==1 is a legal operand set whose answer is simply zero
          if (chk_bad) begin
            acc_q <= '0;
            err_q <= !chk_mod1;
          end else begin
            acc_q <= WIDTH'(1);
            sq_q  <= base_q;
            err_q <= 1'b0;
          end
        end
        MUL: begin
          if (bit_last) begin
            if (exp_q[0]) acc_q <= p1[WIDTH-1:0];
            sq_q  <= p2[WIDTH-1:0];
            exp_q <= exp_q >> 1;
            r1_q  <= '0;
            r2_q  <= '0;
            j_q   <= '0;
            k_q   <= k_q + KW'(1);
          end else begin
            r1_q <= p1;
            r2_q <= p2;
            j_q  <= j_q + JW'(1);
          end
        end
        DONE: begin
          // first DONE cycle publishes the result; it is then held until consumed
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            result_q    <= acc_q;
            error_q     <= err_q;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            error_q     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modex_engine.sv
// Directed bench for modex_engine: vector table of RSA-style operations plus
// back-pressure and mid-operation reset sequences.
`timescale 1ns/1ps
module tb_modex_engine;
  localparam int W     = 16;
  localparam int EW    = 16;
  localparam int LIMIT = 400;

  typedef struct {
    logic [W-1:0]  b;
    logic [EW-1:0] e;
    logic [W-1:0]  m;
    logic [W-1:0]  r;
    logic          er;
    int            lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[10];

  always #5 clk = ~clk;

  modex_engine_if #(.WIDTH(W), .EXP_WIDTH(EW)) bus();

  modex_engine #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [W-1:0] b, input logic [EW-1:0] e, input logic [W-1:0] m);
    @(negedge clk);
    bus.base     = b;
    bus.exponent = e;
    bus.modulus  = m;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int   edges;
    logic busy_ready;
    @(negedge clk);
    chk({tag, " in_ready idle"}, 32'(bus.in_ready), 32'd1);
    start_op(v.b, v.e, v.m);
    edges = 0;
    busy_ready = 1'b0;
    while (!bus.out_valid && edges < LIMIT) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.in_ready) busy_ready = 1'b1;
    end
    chk({tag, " latency"}, 32'(edges), 32'(v.lat));
    chk({tag, " result"}, 32'(bus.result), 32'(v.r));
    chk({tag, " error"}, 32'(bus.error), 32'(v.er));
    chk({tag, " in_ready busy"}, 32'(busy_ready), 32'd0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, " out_valid after hs"}, 32'(bus.out_valid), 32'd0);
    chk({tag, " in_ready after hs"}, 32'(bus.in_ready), 32'd1);
    chk({tag, " error after hs"}, 32'(bus.error), 32'd0);
    chk({tag, " result held"}, 32'(bus.result), 32'(v.r));
  endtask

  initial begin
    int   edges;
    logic stable_bad;
    logic idle_bad;

    vecs[0] = '{b: 16'd65,   e: 16'd17,   m: 16'd3233, r: 16'd2790, er: 1'b0, lat: 258};
    vecs[1] = '{b: 16'd2790, e: 16'd2753, m: 16'd3233, r: 16'd65,   er: 1'b0, lat: 258};
    vecs[2] = '{b: 16'd0,    e: 16'd5,    m: 16'd3233, r: 16'd0,    er: 1'b0, lat: 258};
    vecs[3] = '{b: 16'd7,    e: 16'd0,    m: 16'd3233, r: 16'd1,    er: 1'b0, lat: 258};
    vecs[4] = '{b: 16'd4,    e: 16'd13,   m: 16'd497,  r: 16'd445,  er: 1'b0, lat: 258};
    vecs[5] = '{b: 16'd0,    e: 16'd5,    m: 16'd1,    r: 16'd0,    er: 1'b0, lat: 2};
    vecs[6] = '{b: 16'd3233, e: 16'd17,   m: 16'd3233, r: 16'd0,    er: 1'b1, lat: 2};
    vecs[7] = '{b: 16'd5,    e: 16'd3,    m: 16'd0,    r: 16'd0,    er: 1'b1, lat: 2};
    vecs[8] = '{b: 16'd11,   e: 16'd3,    m: 16'd10,   r: 16'd0,    er: 1'b1, lat: 2};
    vecs[9] = '{b: 16'd3,    e: 16'd4,    m: 16'd10,   r: 16'd1,    er: 1'b0, lat: 258};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.base      = '0;
    bus.exponent  = '0;
    bus.modulus   = '0;

    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset result", 32'(bus.result), 32'd0);
    chk("reset error", 32'(bus.error), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Back-pressure: result must hold while the consumer stalls, and operands are ignored.
    start_op(16'd65, 16'd17, 16'd3233);
    edges = 0;
    while (!bus.out_valid && edges < LIMIT) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk("bp latency", 32'(edges), 32'd258);
    stable_bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.in_valid = c[0];
      bus.base     = 16'd9;
      bus.exponent = 16'd3;
      bus.modulus  = 16'd11;
      @(posedge clk);
      #1;
      if (!bus.out_valid || bus.result != 16'd2790 || bus.error || bus.in_ready) stable_bad = 1'b1;
    end
    chk("bp stable", 32'(stable_bad), 32'd0);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("bp release out_valid", 32'(bus.out_valid), 32'd0);
    chk("bp release in_ready", 32'(bus.in_ready), 32'd1);
    idle_bad = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.out_valid || !bus.in_ready) idle_bad = 1'b1;
    end
    chk("bp no stray op", 32'(idle_bad), 32'd0);

    // Asynchronous reset in the middle of an operation aborts it immediately.
    start_op(16'd65, 16'd17, 16'd3233);
    repeat (100) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst result", 32'(bus.result), 32'd0);
    chk("midrst in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst error", 32'(bus.error), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op(vecs[0], "post-reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/modex_engine.md
Name: modex_engine

Overview:
- Parametrised modular-exponentiation engine: computes result = base^exponent mod modulus for the RSA encrypt/decrypt datapath.
- Generalises the fixed-width modular-exponentiation processor to configurable operand and exponent widths.
- Adds a valid/ready handshake on input and output, operand checking with an error flag, and constant-time execution.
- Sits between the operand memory/sequencer and the result writer.

Parameters:
- WIDTH, 16, bit width of base, modulus and result.
- EXP_WIDTH, 16, bit width of exponent.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- in_valid  input  1  operand set valid.
- in_ready  output  1  engine can accept operands.
- base  input  WIDTH  message/ciphertext operand.
- exponent  input  EXP_WIDTH  public or private exponent.
- modulus  input  WIDTH  RSA modulus n.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  base^exponent mod modulus.
- error  output  1  qualifies result when out_valid is high; operands were illegal.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; in_ready=1; out_valid=0; result=0; error=0.
  - All internal registers are cleared.
  - Reset mid-operation aborts the computation with no output.
- States: IDLE, CHECK, MUL, DONE.
- IDLE:
  - in_ready=1 only in IDLE.
  - On an edge with in_valid&&in_ready, latch base, exponent and modulus → CHECK.
  - Inputs are ignored in every other state.
- CHECK (1 cycle):
  - If modulus<2 or base>=modulus: result=0, error=1 → DONE.
  - Special case modulus==1: result=0, error=0 → DONE.
  - Otherwise: acc=1, sq=base, bit index k=0, step counter j=0 → MUL.
- MUL:
  - Right-to-left square-and-multiply.
  - Each exponent bit k costs exactly WIDTH cycles. Two interleaved shift-add modular multipliers run in parallel: P1=acc*sq mod n and P2=sq*sq mod n.
  - Per cycle, for multiplier bit i=WIDTH-1-j:
    - r=2r; if r>=n then r-=n;
    - if y[i] then r+=x; if r>=n then r-=n.
  - Internal r is WIDTH+1 bits; invariant r<n at all times.
  - After WIDTH cycles:
    - acc=P1 if exponent[k]=1, else unchanged.
    - sq=P2; k++.
  - Squaring is always performed, including after the last bit.
  - After k reaches EXP_WIDTH → DONE.
- Timing: constant-time, with no early exit on leading-zero exponent bits.
  - Acceptance edge = edge 0.
  - out_valid rises at edge EXP_WIDTH*WIDTH+2.
  - Error/modulus==1 path: out_valid rises at edge 2.
- DONE:
  - out_valid=1; result=acc (or 0 on the error or modulus==1 path); error per CHECK.
  - result and error are held stable while out_valid&&!out_ready.
  - On an edge with out_valid&&out_ready: out_valid=0, error=0 → IDLE, in_ready=1 on the next cycle.
  - result keeps its last value after the handshake.
  - No bypass: a new operand set cannot be accepted in the same cycle the result is consumed.
- exponent=0: result=1 (for modulus>=2), error=0, same full latency.
- Operations are non-overlapping; throughput is one operation per latency+handshake.

Test Plan:
- WIDTH=16, EXP_WIDTH=16; base=65, exponent=17, modulus=3233 -> result=2790, error=0; out_valid at edge 258 after acceptance; in_ready=0 throughout.
- base=2790, exponent=2753, modulus=3233 -> result=65; then the next operation base=0, exponent=5, modulus=3233 -> result=0.
- base=7, exponent=0, modulus=3233 -> result=1, error=0 after 258 edges; separately modulus=1 -> result=0, error=0 at edge 2.
- base=3233, exponent=17, modulus=3233 -> error=1, result=0 at edge 2; modulus=0 -> error=1.
- Back-pressure: hold out_ready=0 for 20 cycles after out_valid -> result/out_valid stable and in_valid pulses ignored; release -> IDLE next cycle, in_ready=1.
- Drive rst=0 asynchronously at cycle 100 of an operation -> outputs immediately out_valid=0, result=0, in_ready=1. After release, a fresh 65/17/3233 operation gives 2790 with normal latency.
